// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the MEM/WB pipeline slice.
//   DW_DEF / AW_DEF   default datapath and register-address widths
//   LD_BYTE/HALF/WORD load-size encodings seen on in_ldsize
//   stage_t           per-stage record {valid, regwrite, rd, wdata} at default widths
package pipe_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned AW_DEF = 5;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [AW_DEF-1:0] rd;
        logic [DW_DEF-1:0] wdata;
    } stage_t;

endpackage

// File: rtl/load_extend.sv
// load_extend: aligns a data-memory word by byte offset, then truncates to
// byte/half/word and sign- or zero-extends back to DW. Purely combinational.
//   memdata  in   DW  raw data-memory read word
//   ldsize   in   2   LD_BYTE / LD_HALF / LD_WORD (2'b11 behaves as word)
//   ldsign   in   1   1 = sign-extend sub-word loads
//   ldoff    in   2   byte offset within the word
//   data     out  DW  extended load result
module load_extend
    import pipe_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] memdata,
    input  logic [1:0]    ldsize,
    input  logic          ldsign,
    input  logic [1:0]    ldoff,
    output logic [DW-1:0] data
);

    logic [DW-1:0] aligned;

    assign aligned = memdata >> {ldoff, 3'b000};

    always_comb begin
        data = aligned;
        case (ldsize)
            LD_BYTE: data = {{(DW-8){ldsign & aligned[7]}}, aligned[7:0]};
            LD_HALF: data = {{(DW-16){ldsign & aligned[15]}}, aligned[15:0]};
            LD_WORD: data = aligned;
            default: data = aligned;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: parametrised MEM/WB pipeline register with valid tracking,
// stall, flush, pre-register writeback select and youngest-first forwarding.
// Optional macro MEM_WB_LOAD_EXT_EN inserts load_extend on the memory path.
//   clk, rst                 clock; synchronous active-high reset
//   stall, flush             hold all stages / invalidate all stages (flush wins)
//   in_*                     MEM-stage instruction fields
//   fwd_rs -> fwd_hit/data   forwarding lookup across all in-flight stages
//   out_*                    last-stage register-file write port
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_regwrite,
    input  logic          in_memtoreg,
    input  logic [DW-1:0] in_aluresult,
    input  logic [DW-1:0] in_memdata,
    input  logic [AW-1:0] in_rd,
    input  logic [1:0]    in_ldsize,
    input  logic          in_ldsign,
    input  logic [1:0]    in_ldoff,
    input  logic [AW-1:0] fwd_rs,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          out_valid,
    output logic          out_regwrite,
    output logic [AW-1:0] out_rd,
    output logic [DW-1:0] out_wdata
);

    // Same layout as pipe_pkg::stage_t, sized by this instance's parameters.
    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic [AW-1:0] rd;
        logic [DW-1:0] wdata;
    } rec_t;

    logic [DW-1:0] mem_val;
    rec_t          in_rec;
    rec_t          stg_q [STAGES];

`ifdef MEM_WB_LOAD_EXT_EN
    load_extend #(
        .DW (DW)
    ) u_load_extend (
        .memdata (in_memdata),
        .ldsize  (in_ldsize),
        .ldsign  (in_ldsign),
        .ldoff   (in_ldoff),
        .data    (mem_val)
    );
`else
    logic unused_ld;
    assign unused_ld = ^{in_ldsize, in_ldsign, in_ldoff};
    assign mem_val   = in_memdata;
`endif

    always_comb begin
        in_rec.valid    = in_valid;
        // x0 is hard-wired zero: never a write, never a forward source.
        in_rec.regwrite = in_valid & in_regwrite & (in_rd != '0);
        in_rec.rd       = in_rd;
        in_rec.wdata    = in_memtoreg ? mem_val : in_aluresult;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rec_t src;
        if (k == 0) begin : g_head
            assign src = in_rec;
        end else begin : g_tail
            assign src = stg_q[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stg_q[k] <= '0;
            end else if (flush) begin
                // rd/wdata deliberately hold; only the qualifiers are cleared.
                stg_q[k].valid    <= 1'b0;
                stg_q[k].regwrite <= 1'b0;
            end else if (!stall) begin
                stg_q[k] <= src;
            end
        end
    end

    // Walk oldest to youngest so the youngest match is the last to win.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (stg_q[k].valid && stg_q[k].regwrite && (stg_q[k].rd == fwd_rs) &&
                (fwd_rs != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = stg_q[k].wdata;
            end
        end
    end

    assign out_valid    = stg_q[STAGES-1].valid;
    assign out_regwrite = stg_q[STAGES-1].valid & stg_q[STAGES-1].regwrite;
    assign out_rd       = stg_q[STAGES-1].rd;
    assign out_wdata    = stg_q[STAGES-1].wdata;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: drives a 2-stage and a 3-stage mem_wb_pipe with identical
// stimulus. Each accepted input is pushed into a per-instance expectation
// queue and popped when it leaves the last stage.
module tb_mem_wb_pipe;

    typedef struct {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_regwrite, in_memtoreg;
    logic [31:0] in_aluresult, in_memdata;
    logic [4:0]  in_rd, fwd_rs;
    logic [1:0]  in_ldsize, in_ldoff;
    logic        in_ldsign;

    logic        hit2, hit3, ov2, ov3, orw2, orw3;
    logic [31:0] fd2, fd3, wd2, wd3;
    logic [4:0]  ord2, ord3;

    int n_cmp = 0;
    int n_mis = 0;

    exp_t q2[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    mem_wb_pipe #(.DW(32), .AW(5), .STAGES(2)) u_dut2 (
        .clk (clk), .rst (rst), .stall (stall), .flush (flush),
        .in_valid (in_valid), .in_regwrite (in_regwrite), .in_memtoreg (in_memtoreg),
        .in_aluresult (in_aluresult), .in_memdata (in_memdata), .in_rd (in_rd),
        .in_ldsize (in_ldsize), .in_ldsign (in_ldsign), .in_ldoff (in_ldoff),
        .fwd_rs (fwd_rs), .fwd_hit (hit2), .fwd_data (fd2),
        .out_valid (ov2), .out_regwrite (orw2), .out_rd (ord2), .out_wdata (wd2)
    );

    mem_wb_pipe #(.DW(32), .AW(5), .STAGES(3)) u_dut3 (
        .clk (clk), .rst (rst), .stall (stall), .flush (flush),
        .in_valid (in_valid), .in_regwrite (in_regwrite), .in_memtoreg (in_memtoreg),
        .in_aluresult (in_aluresult), .in_memdata (in_memdata), .in_rd (in_rd),
        .in_ldsize (in_ldsize), .in_ldsign (in_ldsign), .in_ldoff (in_ldoff),
        .fwd_rs (fwd_rs), .fwd_hit (hit3), .fwd_data (fd3),
        .out_valid (ov3), .out_regwrite (orw3), .out_rd (ord3), .out_wdata (wd3)
    );

    function automatic logic [31:0] exp_mem(input logic [31:0] m, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] off);
        logic [31:0] a;
        a = m;
`ifdef MEM_WB_LOAD_EXT_EN
        a = m >> (8 * off);
        if (sz == 2'b00) a = {{24{sg & a[7]}}, a[7:0]};
        else if (sz == 2'b01) a = {{16{sg & a[15]}}, a[15:0]};
`else
        if (sz == 2'b11 && sg && off == 2'b11) a = m;
`endif
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fwd_model(input exp_t q[$], output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (!h && q[i].valid && q[i].regwrite && q[i].rd == fwd_rs && fwd_rs != 0) begin
                h = 1'b1;
                d = q[i].wdata;
            end
        end
    endtask

    task automatic check_all();
        logic        h;
        logic [31:0] d;
        exp_t        e;
        e = q2[q2.size()-1];
        chk("s2_valid", {31'b0, ov2}, {31'b0, e.valid});
        chk("s2_regwrite", {31'b0, orw2}, {31'b0, e.valid & e.regwrite});
        chk("s2_rd", {27'b0, ord2}, {27'b0, e.rd});
        chk("s2_wdata", wd2, e.wdata);
        fwd_model(q2, h, d);
        chk("s2_fwd_hit", {31'b0, hit2}, {31'b0, h});
        chk("s2_fwd_data", fd2, d);
        e = q3[q3.size()-1];
        chk("s3_valid", {31'b0, ov3}, {31'b0, e.valid});
        chk("s3_regwrite", {31'b0, orw3}, {31'b0, e.valid & e.regwrite});
        chk("s3_rd", {27'b0, ord3}, {27'b0, e.rd});
        chk("s3_wdata", wd3, e.wdata);
        fwd_model(q3, h, d);
        chk("s3_fwd_hit", {31'b0, hit3}, {31'b0, h});
        chk("s3_fwd_data", fd3, d);
    endtask

    // Drive one cycle's worth of inputs, clock, update expectations, then check.
    task automatic step(input logic v, input logic rw, input logic mtr, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] rd, input logic st,
                        input logic fl, input logic r);
        exp_t e;
        in_valid = v; in_regwrite = rw; in_memtoreg = mtr;
        in_aluresult = alu; in_memdata = mem; in_rd = rd;
        stall = st; flush = fl; rst = r;
        e.valid    = v;
        e.regwrite = v & rw & (rd != 0);
        e.rd       = rd;
        e.wdata    = mtr ? exp_mem(mem, in_ldsize, in_ldsign, in_ldoff) : alu;
        @(posedge clk);
        if (r) begin
            foreach (q2[i]) q2[i] = '{1'b0, 1'b0, 5'd0, 32'd0};
            foreach (q3[i]) q3[i] = '{1'b0, 1'b0, 5'd0, 32'd0};
        end else if (fl) begin
            foreach (q2[i]) begin q2[i].valid = 1'b0; q2[i].regwrite = 1'b0; end
            foreach (q3[i]) begin q3[i].valid = 1'b0; q3[i].regwrite = 1'b0; end
        end else if (!st) begin
            q2.push_front(e); void'(q2.pop_back());
            q3.push_front(e); void'(q3.pop_back());
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) q2.push_back('{1'b1, 1'b1, 5'h1f, 32'hx});
        for (int i = 0; i < 3; i++) q3.push_back('{1'b1, 1'b1, 5'h1f, 32'hx});
        in_ldsize = 2'b10; in_ldsign = 1'b0; in_ldoff = 2'b00; fwd_rs = 5'd0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_regwrite", {31'b0, orw3}, 32'd0);

        // ALU write: visible on the 2-stage output exactly two edges later
        step(1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("alu_not_early", {31'b0, orw2}, 32'd0);
        idle();
        chk("alu_regwrite", {31'b0, orw2}, 32'd1);
        chk("alu_rd", {27'b0, ord2}, 32'd5);
        chk("alu_wdata", wd2, 32'h0000_1234);

        // Load to x0: travels as valid but never writes or forwards
        fwd_rs = 5'd0;
        step(1'b1, 1'b1, 1'b1, 32'd0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x0_fwd_hit", {31'b0, hit2}, 32'd0);
        idle();
        chk("x0_valid", {31'b0, ov2}, 32'd1);
        chk("x0_regwrite", {31'b0, orw2}, 32'd0);
        chk("x0_wdata", wd2, 32'hDEAD_BEEF);

        // Stall freezes everything; flush with stall clears validity
        step(1'b1, 1'b1, 1'b0, 32'h0000_0033, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 32'h0000_0099, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0077, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", {31'b0, ov3}, 32'd0);

        // Youngest-first forwarding
        fwd_rs = 5'd7;
        step(1'b1, 1'b1, 1'b0, 32'h0000_000A, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0000_000B, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("fwd_hit", {31'b0, hit3}, 32'd1);
        chk("fwd_youngest", fd3, 32'h0000_000B);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("fwd_after_flush", {31'b0, hit3}, 32'd0);

        // Reset mid-stream wins over simultaneous flush/stall
        for (int i = 1; i <= 3; i++)
            step(1'b1, 1'b1, 1'b0, 32'h100 + i, 32'd0, 5'(i), 1'b0, 1'b0, 1'b0);
        fwd_rs = 5'd1;
        step(1'b1, 1'b1, 1'b0, 32'h0000_0555, 32'd0, 5'd1, 1'b1, 1'b1, 1'b1);
        chk("rst_wdata", wd3, 32'd0);
        chk("rst_fwd_hit", {31'b0, hit3}, 32'd0);

        // Sub-word loads (extraction only with MEM_WB_LOAD_EXT_EN)
        in_ldsize = 2'b00; in_ldsign = 1'b1; in_ldoff = 2'd1;
        step(1'b1, 1'b1, 1'b1, 32'd0, 32'h1234_80FF, 5'd10, 1'b0, 1'b0, 1'b0);
        in_ldsize = 2'b01; in_ldsign = 1'b0; in_ldoff = 2'd2;
        step(1'b1, 1'b1, 1'b1, 32'd0, 32'h1234_80FF, 5'd11, 1'b0, 1'b0, 1'b0);
        in_ldsize = 2'b10; in_ldsign = 1'b0; in_ldoff = 2'd0;
`ifdef MEM_WB_LOAD_EXT_EN
        chk("ld_byte_signed", wd2, 32'hFFFF_FF80);
        idle();
        chk("ld_half_unsigned", wd2, 32'h0000_1234);
`else
        chk("ld_raw_byte", wd2, 32'h1234_80FF);
        idle();
        chk("ld_raw_half", wd2, 32'h1234_80FF);
`endif

        // Randomised traffic with occasional stall/flush
        for (int i = 0; i < 60; i++) begin
            fwd_rs = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline register: successor to the fixed single-stage MEM→WB latch.
- Configurable data width, register-address width and stage count (STAGES ≥ 1).
- Adds valid tracking, stall, flush, and a registered writeback-data select.
- Includes a youngest-first forwarding lookup across all in-flight stages. Sits between data-memory/ALU result and register-file write port.

Parameters:
- DW, 32, datapath width (ALU result, memory data, writeback data)
- AW, 5, register address width
- STAGES, 1, number of register stages between MEM and WB (1..4)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold all stages (no shift)
- flush  input  1  invalidate all stages
- in_valid  input  1  MEM-stage instruction valid
- in_regwrite  input  1  instruction writes register file
- in_memtoreg  input  1  1 = write memory data, 0 = write ALU result
- in_aluresult  input  DW  ALU result from EX/MEM
- in_memdata  input  DW  data-memory read data
- in_rd  input  AW  destination register
- in_ldsize  input  2  load size 00 byte, 01 half, 10 word (used only with LOAD_EXT_EN)
- in_ldsign  input  1  sign-extend sub-word load (LOAD_EXT_EN only)
- in_ldoff  input  2  byte offset within word (LOAD_EXT_EN only)
- fwd_rs  input  AW  source register queried by hazard/forward unit
- fwd_hit  output  1  some in-flight stage writes fwd_rs
- fwd_data  output  DW  writeback data of youngest matching stage
- out_valid  output  1  last-stage valid
- out_regwrite  output  1  register-file write enable
- out_rd  output  AW  register-file write address
- out_wdata  output  DW  register-file write data

Behaviour:
- Single clock, clk. Reset (rst) is synchronous and active-high.
- Each stage holds: valid, regwrite, rd, wdata.
- Reset: all stages valid=0, regwrite=0, rd=0, wdata=0; outputs therefore 0; fwd_hit=0. Reset has priority over flush and stall.
- Priority each cycle:
  - rst: reset all stages.
  - else flush: all valid and regwrite cleared; rd/wdata don't-care, hold.
  - else stall: all stages hold.
  - else shift: stage0 ← inputs, stage k ← stage k-1.
- Stage0 capture:
  - wdata = in_memtoreg ? in_memdata : in_aluresult, selected before the register.
  - regwrite = in_valid & in_regwrite & (in_rd != 0).
- Latency: STAGES cycles from in_* to out_*. Throughput 1/cycle when not stalled.
- Outputs taken from the last stage:
  - out_regwrite = valid & regwrite.
  - out_valid = valid.
- Forwarding (combinational from registered state):
  - Matching stage: valid & regwrite & rd == fwd_rs. fwd_rs == 0 never hits.
  - Youngest match wins; stage0 has highest priority.
  - No match: fwd_hit=0, fwd_data=0.
- Flush and stall together: flush wins. Stall during flush has no extra effect.
- rst asserted mid-stream: in-flight entries are lost, outputs 0 on the next edge.
- STAGES=1 degenerates to a valid-gated, pre-muxed version of the single latch.

Optional Feature:
- Macro: MEM_WB_LOAD_EXT_EN.
- Defined:
  - Memory path is aligned before the select: in_memdata >> (8*in_ldoff).
  - Then truncated to byte/half/word per in_ldsize, and sign- or zero-extended per in_ldsign, to DW.
  - The extractor is combinational, ahead of stage0 (latency unchanged).
  - in_ldsize=11 is treated as word.
- Undefined: in_ldsize/in_ldsign/in_ldoff are ignored; in_memdata is used unmodified.

Decomposition:
- Shared package pipe_pkg:
  - DW/AW defaults.
  - Load-size encodings LD_BYTE=2'b00, LD_HALF=2'b01, LD_WORD=2'b10.
  - Stage-record typedef {valid, regwrite, rd, wdata}.
- One natural sub-module: load_extend (MEM_WB_LOAD_EXT_EN path only), instantiated once.
- Stage chain and forward search stay in mem_wb_pipe via generate loop.

Test Plan:
- STAGES=2, ALU write: in_valid=1, regwrite=1, memtoreg=0, alu=0x0000_1234, rd=5 → out_regwrite=1, rd=5, wdata=0x1234 exactly 2 cycles later.
- Load with rd=0: memtoreg=1, memdata=0xDEAD_BEEF, rd=0 → out_regwrite=0 on its exit cycle; fwd_rs=0 → fwd_hit=0.
- Stall/flush: issue rd=3 then stall 3 cycles → outputs frozen. Assert flush with stall → next cycle all valid=0; flush wins.
- Forward priority, STAGES=3: rd=7 with 0xA then rd=7 with 0xB back-to-back, fwd_rs=7 → fwd_hit=1, fwd_data=0xB. After the 0xB instruction's stage is flushed → fwd_hit=0.
- Reset mid-stream: pipeline full of valid writes, rst=1 one cycle → next edge all outputs 0, fwd_hit=0; rst takes precedence over simultaneous flush/stall.
- MEM_WB_LOAD_EXT_EN: memdata=0x1234_80FF, memtoreg=1:
  - byte, off=1, signed → wdata=0xFFFF_FF80.
  - half, off=2, unsigned → wdata=0x0000_1234.
